// File: rtl/vx_mem_responder_pkg.sv
// Shared types and constants for the Vortex memory-side responder.
// Word/tag/latency widths are fixed here because they shape rsp_entry_t.
package vx_mem_responder_pkg;

  localparam int DATA_WIDTH      = 512;
  localparam int TAG_WIDTH       = 8;
  localparam int BYTEEN_WIDTH    = DATA_WIDTH / 8;
  localparam int RSP_DELAY       = 15;
  localparam int CNT_WIDTH       = $clog2(RSP_DELAY) + 1;

  localparam int DEF_ADDR_WIDTH  = 26;
  localparam int DEF_MEM_DEPTH   = 64;
  localparam int DEF_QUEUE_DEPTH = 4;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t RSP_CNT_INIT = cnt_t'(RSP_DELAY - 1);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
    cnt_t                  cnt;
  } rsp_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } rsp_state_t;

  function automatic cnt_t sat_dec(input cnt_t c);
    return (c == '0) ? c : c - cnt_t'(1);
  endfunction

endpackage

// File: rtl/vx_mem_rsp_queue.sv
// In-order FIFO of pending read responses; every entry counts down to zero
// and the head is presentable once its count has expired.
module vx_mem_rsp_queue
  import vx_mem_responder_pkg::*;
#(
  parameter int DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  rsp_entry_t             push_entry_i,
  input  logic                   pop_i,
  output rsp_entry_t             head_o,
  output logic                   head_ready_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   nxt_empty_o,
  output logic                   nxt_head_ready_o
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   count_t;

  rsp_entry_t entries_q [DEPTH];
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  count_t     count_q, count_d;
  logic       head_is_new;

  // NOTE: the entry array is plain storage with no reset; occupancy is
  // tracked by count/pointers, so stale entries are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_q[i].cnt <= sat_dec(entries_q[i].cnt);
    end
    if (push_i) begin
      entries_q[wr_ptr_q] <= push_entry_i;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q + ptr_t'(push_i);
    rd_ptr_d = rd_ptr_q + ptr_t'(pop_i);
    count_d  = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + count_t'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - count_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Next cycle's head is the freshly pushed entry when it lands on the new read pointer.
  assign head_is_new      = push_i && (wr_ptr_q == rd_ptr_d);
  assign nxt_empty_o      = (count_d == '0);
  assign nxt_head_ready_o = head_is_new ? (RSP_CNT_INIT == '0)
                                        : (entries_q[rd_ptr_d].cnt <= cnt_t'(1));

  assign head_o       = entries_q[rd_ptr_q];
  assign head_ready_o = (count_q != '0) && (entries_q[rd_ptr_q].cnt == '0);
  assign count_o      = count_q;

endmodule

// File: rtl/vx_mem_responder.sv
// Backing-memory responder for the Vortex mem_req/mem_rsp interface.
// Define VX_MEM_RESPONDER_THROTTLE_EN to add LFSR-driven request back-pressure.
module vx_mem_responder
  import vx_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [BYTEEN_WIDTH-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy,
  output logic                    addr_oob
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int QCNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [IDX_W-1:0]      idx;
  logic                  oob;
  logic                  accept, wr_en, push, pop;
  logic [DATA_WIDTH-1:0] rd_data;
  rsp_entry_t            push_entry, head;
  logic                  head_ready, nxt_empty, nxt_head_ready;
  logic [QCNT_W-1:0]     q_count;
  logic                  init_done_q;
  logic                  addr_oob_q;
  logic                  throttle;
  rsp_state_t            state_q, state_d;

  assign idx     = mem_req_addr[IDX_W-1:0];
  assign oob     = (mem_req_addr >= ADDR_WIDTH'(MEM_DEPTH));
  assign accept  = mem_req_valid && mem_req_ready;
  assign wr_en   = accept && mem_req_rw && !oob;
  assign push    = accept && !mem_req_rw;
  assign pop     = mem_rsp_valid && mem_rsp_ready;
  assign rd_data = oob ? '0 : mem_q[idx];

  assign push_entry = '{tag: mem_req_tag, data: rd_data, cnt: RSP_CNT_INIT};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTEEN_WIDTH; b++) begin
        if (mem_req_byteen[b]) begin
          mem_q[idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
        end
      end
    end
  end

  vx_mem_rsp_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk              (clk),
    .reset            (reset),
    .push_i           (push),
    .push_entry_i     (push_entry),
    .pop_i            (pop),
    .head_o           (head),
    .head_ready_o     (head_ready),
    .count_o          (q_count),
    .nxt_empty_o      (nxt_empty),
    .nxt_head_ready_o (nxt_head_ready)
  );

`ifdef VX_MEM_RESPONDER_THROTTLE_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign throttle = (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign throttle = 1'b0;
`endif

  // State is chosen from what the queue head will look like after this edge,
  // so a read accepted in cycle T is presented exactly in cycle T+RSP_DELAY.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (push) state_d = nxt_head_ready ? PRESENT : WAIT;
      end
      WAIT: begin
        if (nxt_head_ready) state_d = PRESENT;
      end
      PRESENT: begin
        if (pop) begin
          if (nxt_empty)           state_d = IDLE;
          else if (nxt_head_ready) state_d = PRESENT;
          else                     state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      init_done_q <= 1'b0;
      addr_oob_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= 1'b1;
      if (accept && oob) addr_oob_q <= 1'b1;
    end
  end

  assign mem_req_ready = init_done_q && (q_count < QCNT_W'(QUEUE_DEPTH)) && !throttle;
  assign mem_rsp_valid = (state_q == PRESENT) && head_ready;
  assign mem_rsp_data  = mem_rsp_valid ? head.data : '0;
  assign mem_rsp_tag   = mem_rsp_valid ? head.tag  : '0;
  assign busy          = (q_count != '0);
  assign addr_oob      = addr_oob_q;

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed scoreboard bench for vx_mem_responder: stimulus pushes expected
// read responses, a monitor compares them as the DUT presents them.
module tb_vx_mem_responder;
  import vx_mem_responder_pkg::*;

  localparam int LAT = 15;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    mem_req_valid;
  logic                    mem_req_rw;
  logic [BYTEEN_WIDTH-1:0] mem_req_byteen;
  logic [25:0]             mem_req_addr;
  logic [DATA_WIDTH-1:0]   mem_req_data;
  logic [TAG_WIDTH-1:0]    mem_req_tag;
  logic                    mem_req_ready;
  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rsp_data;
  logic [TAG_WIDTH-1:0]    mem_rsp_tag;
  logic                    mem_rsp_ready;
  logic                    busy;
  logic                    addr_oob;

  vx_mem_responder dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_byteen (mem_req_byteen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_tag    (mem_req_tag),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_tag    (mem_rsp_tag),
    .mem_rsp_ready  (mem_rsp_ready),
    .busy           (busy),
    .addr_oob       (addr_oob)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
    int                    due;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [DATA_WIDTH-1:0] act,
                       input logic [DATA_WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge; t_acc is the cycle in which the request was accepted.
  task automatic issue(input logic rw, input logic [25:0] addr, input logic [63:0] be,
                       input logic [DATA_WIDTH-1:0] data, input logic [7:0] tag,
                       output int t_acc);
    int  waited;
    bit  rdy;
    waited         = 0;
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = addr;
    mem_req_byteen = be;
    mem_req_data   = data;
    mem_req_tag    = tag;
    forever begin
      rdy   = mem_req_ready;
      t_acc = cyc;
      @(posedge clk);
      if (rdy) break;
      waited++;
      if (waited >= 100) break;
      @(negedge clk);
    end
    if (!rdy) begin
      check("req_accept_timeout", 0, 1);
      t_acc = -1;
    end
    @(negedge clk);
    mem_req_valid = 1'b0;
  endtask

  task automatic write_word(input logic [25:0] addr, input logic [63:0] be,
                            input logic [DATA_WIDTH-1:0] data);
    int t;
    issue(1'b1, addr, be, data, 8'h00, t);
  endtask

  task automatic read_word(input logic [25:0] addr, input logic [7:0] tag,
                           input logic [DATA_WIDTH-1:0] exp_data, output int t);
    issue(1'b0, addr, '0, '0, tag, t);
    if (t >= 0) exp_q.push_back('{tag: tag, data: exp_data, due: t + LAT});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
    check("busy_after_drain", busy, 0);
    check("valid_after_drain", mem_rsp_valid, 0);
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    int   last_pop;
    int   exp_first;
    bit   seen;
    exp_t e;
    last_pop = -1000;
    seen     = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        seen     = 0;
        last_pop = -1000;
      end else if (mem_rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = exp_q[0];
          if (!seen) begin
            exp_first = (e.due > last_pop + 1) ? e.due : last_pop + 1;
            check("rsp_first_cycle", cyc, exp_first);
            seen = 1;
          end
          check("rsp_tag", mem_rsp_tag, e.tag);
          check("rsp_data", mem_rsp_data, e.data);
          if (mem_rsp_ready) begin
            void'(exp_q.pop_front());
            last_pop = cyc;
            seen     = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_WIDTH-1:0] dead;
    logic [DATA_WIDTH-1:0] part;
    logic [DATA_WIDTH-1:0] ab;
    int t, t0, t5;

    dead = {16{32'hDEADBEEF}};
    part = '1;
    part[7:0] = 8'hAB;
    ab = '0;
    ab[7:0] = 8'hAB;

    reset          = 1'b1;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_byteen = '0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    mem_req_tag    = '0;
    mem_rsp_ready  = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_req_ready", mem_req_ready, 0);
    check("rst_rsp_valid", mem_rsp_valid, 0);
    check("rst_rsp_data", mem_rsp_data, 0);
    check("rst_rsp_tag", mem_rsp_tag, 0);
    check("rst_busy", busy, 0);
    check("rst_addr_oob", addr_oob, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", mem_req_ready, 1);

    // 1: full write then read, exact latency
    write_word(26'd3, '1, dead);
    read_word(26'd3, 8'h11, dead, t);
    drain();

    // 2: partial write over a zero word
    write_word(26'd5, '1, '0);
    write_word(26'd5, 64'h1, part);
    read_word(26'd5, 8'h12, ab, t);
    drain();

    // 3: five back-to-back reads, queue fills after the fourth
    read_word(26'd3, 8'h21, dead, t0);
    read_word(26'd5, 8'h22, ab, t);
    read_word(26'd3, 8'h23, dead, t);
    read_word(26'd5, 8'h24, ab, t);
    check("req_ready_full", mem_req_ready, 0);
    check("busy_full", busy, 1);
    read_word(26'd3, 8'h25, dead, t5);
    check("fifth_accept_cycle", t5, t0 + LAT + 1);
    drain();

    // 4: hold the head with rsp_ready low
    mem_rsp_ready = 1'b0;
    read_word(26'd3, 8'h31, dead, t);
    read_word(26'd5, 8'h32, ab, t);
    check("busy_pending", busy, 1);
    repeat (25) @(negedge clk);
    check("held_valid", mem_rsp_valid, 1);
    check("held_tag", mem_rsp_tag, 8'h31);
    mem_rsp_ready = 1'b1;
    drain();

    // 5: out-of-bounds read and write
    check("oob_clear", addr_oob, 0);
    read_word(26'd100, 8'h55, '0, t);
    write_word(26'd67, '1, '1);
    drain();
    check("oob_set", addr_oob, 1);
    read_word(26'd3, 8'h56, dead, t);
    drain();
    check("oob_sticky", addr_oob, 1);

    // 6: reset with reads in flight, store retained
    read_word(26'd3, 8'h61, dead, t);
    read_word(26'd5, 8'h62, ab, t);
    read_word(26'd3, 8'h63, dead, t);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_rsp_valid", mem_rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", mem_req_ready, 0);
    check("mid_rst_addr_oob", addr_oob, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rerst_req_ready", mem_req_ready, 1);
    read_word(26'd5, 8'h71, ab, t);
    read_word(26'd3, 8'h72, dead, t);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
